regfile_write_arbiter: RTL and testbench

Shares the single write port of the 4×8-bit register file between two writeback requesters: req0 (ALU result) and req1 (memory load). Each requester gets a one-entry holding slot with a valid/ready handshake. A round-robin arbiter drains the slots into registered `RegWrite`/`WriteR`/`WriteD` outputs, which connect directly to the register file. A per-register pending scoreboard lets the decode stage stall on reads of registers with writes still in flight.

---
 rtl/regarb_pkg.sv | 21 ++
 rtl/regarb_slot.sv | 32 +++
 rtl/regfile_write_arbiter.sv | 162 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regarb_pkg.sv
// Shared definitions for the register-file write arbiter: width defaults, grant codes, slot record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regarb_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;

    // Encoding of the grant output: which source produced the current RegWrite cycle
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_REQ0 = 2'b01;
    localparam logic [1:0] GNT_REQ1 = 2'b10;

    // One held write: valid flag, destination register, data (default widths)
    typedef struct packed {
        logic                  v;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } slot_t;

endpackage

// File: rtl/regarb_slot.sv
// One-entry holding buffer for a writeback requester with a valid/ready handshake.
// Latency: entry visible the cycle after the accepting edge.
// Backpressure: ready only when empty or being drained this cycle; 0 while in reset.
module regarb_slot
    import regarb_pkg::*;
#(
    parameter type entryT = slot_t
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  inValid,
    output logic  inReady,
    input  entryT inEntry,
    input  logic  granted,
    output entryT entry
);

    // A slot being drained at this edge can be refilled at the same edge
    assign inReady = rst_n && (!entry.v || granted);

    // Capture a new write on handshake (caller presents v=1), otherwise empty on grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= '0;
        end else if (inValid && inReady) begin
            entry <= inEntry;
        end else if (granted) begin
            entry.v <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU (req0) and load (req1) writeback; optional REGARB_BYPASS_EN adds a forwarding read port.
// Latency: RegWrite asserted the cycle after a slot fills when uncontended; a full slot is granted within 2 cycles.
// Backpressure: reqN_ready drops while its slot holds an ungranted write; one write per cycle in total.
module regfile_write_arbiter
    import regarb_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int ADDR_W = DEF_ADDR_W,
    localparam int NREG   = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
`ifdef REGARB_BYPASS_EN
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteR,
    output logic [DATA_W-1:0] WriteD,
    output logic [NREG-1:0]   pend,
    output logic [1:0]        grant
);

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } slotT;

    slotT in0, in1, slot0, slot1;
    logic gnt0, gnt1, pick1;
    logic load0, load1;
    logic ageBit;   // 1: slot1 holds the older write
    logic rrPtr;    // 0: req0 favoured on a different-address tie, 1: req1

    assign in0   = '{v: 1'b1, addr: req0_addr, data: req0_data};
    assign in1   = '{v: 1'b1, addr: req1_addr, data: req1_data};
    assign load0 = req0_valid && req0_ready;
    assign load1 = req1_valid && req1_ready;

    regarb_slot #(.entryT(slotT)) uSlot0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .inValid (req0_valid),
        .inReady (req0_ready),
        .inEntry (in0),
        .granted (gnt0),
        .entry   (slot0)
    );

    regarb_slot #(.entryT(slotT)) uSlot1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .inValid (req1_valid),
        .inReady (req1_ready),
        .inEntry (in1),
        .granted (gnt1),
        .entry   (slot1)
    );

    // Pick a winner: lone full slot wins; same address goes to the older write; otherwise round-robin
    always_comb begin
        pick1 = 1'b0;
        if (slot0.v && slot1.v) begin
            pick1 = (slot0.addr == slot1.addr) ? ageBit : rrPtr;
        end else begin
            pick1 = slot1.v;
        end
        gnt0 = slot0.v && !pick1;
        gnt1 = slot1.v && pick1;
    end

    // Track relative age of the slots and rotate the round-robin pointer after every grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ageBit <= 1'b0;
            rrPtr  <= 1'b0;
        end else begin
            // Simultaneous accepts leave req0 older so req1's value lands last
            if (load0 && !load1) begin
                ageBit <= 1'b1;
            end else if (load1) begin
                ageBit <= 1'b0;
            end
            if (gnt0) begin
                rrPtr <= 1'b1;
            end else if (gnt1) begin
                rrPtr <= 1'b0;
            end
        end
    end

    // Output stage driving the register file; index/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite <= 1'b0;
            WriteR   <= '0;
            WriteD   <= '0;
            grant    <= GNT_NONE;
        end else if (gnt0) begin
            RegWrite <= 1'b1;
            WriteR   <= slot0.addr;
            WriteD   <= slot0.data;
            grant    <= GNT_REQ0;
        end else if (gnt1) begin
            RegWrite <= 1'b1;
            WriteR   <= slot1.addr;
            WriteD   <= slot1.data;
            grant    <= GNT_REQ1;
        end else begin
            RegWrite <= 1'b0;
            grant    <= GNT_NONE;
        end
    end

    // Pending scoreboard: every register with a write still held in a slot or on the write port
    always_comb begin
        pend = '0;
        if (slot0.v) begin
            pend[slot0.addr] = 1'b1;
        end
        if (slot1.v) begin
            pend[slot1.addr] = 1'b1;
        end
        if (RegWrite) begin
            pend[WriteR] = 1'b1;
        end
    end

`ifdef REGARB_BYPASS_EN
    logic hit0, hit1, hitOut;

    assign hit0   = slot0.v && (slot0.addr == fwd_addr);
    assign hit1   = slot1.v && (slot1.addr == fwd_addr);
    assign hitOut = RegWrite && (WriteR == fwd_addr);
    assign fwd_hit = pend[fwd_addr];

    // Forward the newest pending value: younger slot, then older slot, then write port
    always_comb begin
        fwd_data = '0;
        if (hit0 && hit1) begin
            fwd_data = ageBit ? slot0.data : slot1.data;
        end else if (hit0) begin
            fwd_data = slot0.data;
        end else if (hit1) begin
            fwd_data = slot1.data;
        end else if (hitOut) begin
            fwd_data = WriteD;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_ready;
    logic [1:0] req0_addr;
    logic [7:0] req0_data;
    logic       req1_valid, req1_ready;
    logic [1:0] req1_addr;
    logic [7:0] req1_data;
    logic       RegWrite;
    logic [1:0] WriteR;
    logic [7:0] WriteD;
    logic [3:0] pend;
    logic [1:0] grant;
`ifdef REGARB_BYPASS_EN
    logic [1:0] fwd_addr;
    logic       fwd_hit;
    logic [7:0] fwd_data;
`endif

    int tests = 0;
    int fails = 0;

    regfile_write_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
`ifdef REGARB_BYPASS_EN
        .fwd_addr   (fwd_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
`endif
        .RegWrite   (RegWrite),
        .WriteR     (WriteR),
        .WriteD     (WriteD),
        .pend       (pend),
        .grant      (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        tests++; if (RegWrite !== 1'b0) begin fails++; $display("FAIL reset_regwrite: got %b expected 0", RegWrite); end
        tests++; if (WriteR !== 2'd0) begin fails++; $display("FAIL reset_writer: got %0d expected 0", WriteR); end
        tests++; if (WriteD !== 8'h00) begin fails++; $display("FAIL reset_writed: got %h expected 00", WriteD); end
        tests++; if (grant !== 2'b00) begin fails++; $display("FAIL reset_grant: got %b expected 00", grant); end
        tests++; if (pend !== 4'b0000) begin fails++; $display("FAIL reset_pend: got %b expected 0000", pend); end
        tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready); end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b%b expected 11", req0_ready, req1_ready); end
    endtask

    task automatic test_single_write();
        do_reset();
        req0_valid = 1'b1; req0_addr = 2'd0; req0_data = 8'hAA;
        tick();
        idle_inputs();
        tests++; if (pend !== 4'b0001 || RegWrite !== 1'b0) begin fails++; $display("FAIL single_held: got pend=%b we=%b expected 0001 0", pend, RegWrite); end
        tick();
        tests++; if (RegWrite !== 1'b1 || WriteR !== 2'd0 || WriteD !== 8'hAA || grant !== 2'b01) begin
            fails++; $display("FAIL single_write: got we=%b r=%0d d=%h g=%b expected 1 0 aa 01", RegWrite, WriteR, WriteD, grant); end
        tests++; if (pend !== 4'b0001) begin fails++; $display("FAIL single_pend: got %b expected 0001", pend); end
        tick();
        tests++; if (RegWrite !== 1'b0 || grant !== 2'b00 || pend !== 4'b0000) begin
            fails++; $display("FAIL single_done: got we=%b g=%b pend=%b expected 0 00 0000", RegWrite, grant, pend); end
        tests++; if (WriteD !== 8'hAA) begin fails++; $display("FAIL single_hold: got %h expected aa", WriteD); end
    endtask

    task automatic test_dual_diff_addr();
        do_reset();
        req0_valid = 1'b1; req0_addr = 2'd1; req0_data = 8'hFF;
        req1_valid = 1'b1; req1_addr = 2'd2; req1_data = 8'h11;
        #1;
        tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin fails++; $display("FAIL dual_ready: got %b%b expected 11", req0_ready, req1_ready); end
        tick();
        idle_inputs();
        tick();
        tests++; if (RegWrite !== 1'b1 || WriteR !== 2'd1 || WriteD !== 8'hFF || grant !== 2'b01) begin
            fails++; $display("FAIL dual_first: got we=%b r=%0d d=%h g=%b expected 1 1 ff 01", RegWrite, WriteR, WriteD, grant); end
        tests++; if (pend !== 4'b0110) begin fails++; $display("FAIL dual_pend: got %b expected 0110", pend); end
        tick();
        tests++; if (RegWrite !== 1'b1 || WriteR !== 2'd2 || WriteD !== 8'h11 || grant !== 2'b10) begin
            fails++; $display("FAIL dual_second: got we=%b r=%0d d=%h g=%b expected 1 2 11 10", RegWrite, WriteR, WriteD, grant); end
        tick();
        tests++; if (RegWrite !== 1'b0 || pend !== 4'b0000) begin fails++; $display("FAIL dual_done: got we=%b pend=%b expected 0 0000", RegWrite, pend); end
    endtask

    task automatic test_same_addr();
        do_reset();
        req0_valid = 1'b1; req0_addr = 2'd3; req0_data = 8'hAB;
        req1_valid = 1'b1; req1_addr = 2'd3; req1_data = 8'h5C;
        tick();
        idle_inputs();
        tick();
        tests++; if (RegWrite !== 1'b1 || WriteD !== 8'hAB || grant !== 2'b01 || pend !== 4'b1000) begin
            fails++; $display("FAIL same_first: got we=%b d=%h g=%b pend=%b expected 1 ab 01 1000", RegWrite, WriteD, grant, pend); end
        tick();
        tests++; if (RegWrite !== 1'b1 || WriteD !== 8'h5C || grant !== 2'b10 || pend !== 4'b1000) begin
            fails++; $display("FAIL same_second: got we=%b d=%h g=%b pend=%b expected 1 5c 10 1000", RegWrite, WriteD, grant, pend); end
        tick();
        tests++; if (RegWrite !== 1'b0 || pend !== 4'b0000) begin fails++; $display("FAIL same_done: got we=%b pend=%b expected 0 0000", RegWrite, pend); end
    endtask

    task automatic test_back_to_back();
        int sent0, sent1, k;
        logic acc0, acc1;
        logic [1:0] expG, expR;
        logic [7:0] expD;
        do_reset();
        sent0 = 0; sent1 = 0; k = 0;
        for (int cyc = 0; cyc < 40 && k < 16; cyc++) begin
            req0_valid = (sent0 < 8); req0_addr = 2'd0; req0_data = 8'(sent0);
            req1_valid = (sent1 < 8); req1_addr = 2'd1; req1_data = 8'(8'h80 + sent1);
            #1;
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            tick();
            if (acc0) sent0++;
            if (acc1) sent1++;
            if (RegWrite) begin
                expG = (k % 2 == 1) ? 2'b10 : 2'b01;
                expR = (k % 2 == 1) ? 2'd1 : 2'd0;
                expD = (k % 2 == 1) ? 8'(8'h80 + k / 2) : 8'(k / 2);
                tests++; if (grant !== expG || WriteR !== expR || WriteD !== expD) begin
                    fails++; $display("FAIL stream_write%0d: got g=%b r=%0d d=%h expected %b %0d %h", k, grant, WriteR, WriteD, expG, expR, expD); end
                k++;
            end else if (k > 0) begin
                tests++; fails++;
                $display("FAIL stream_gap: got idle write port after %0d writes expected continuous", k);
            end
        end
        idle_inputs();
        tests++; if (k != 16) begin fails++; $display("FAIL stream_count: got %0d writes expected 16", k); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        req0_valid = 1'b1; req0_addr = 2'd2; req0_data = 8'h77;
        req1_valid = 1'b1; req1_addr = 2'd3; req1_data = 8'h99;
        tick();
        idle_inputs();
        tick();
        tests++; if (RegWrite !== 1'b1 || WriteD !== 8'h77) begin fails++; $display("FAIL midrst_pre: got we=%b d=%h expected 1 77", RegWrite, WriteD); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (RegWrite !== 1'b0 || pend !== 4'b0000 || grant !== 2'b00) begin
            fails++; $display("FAIL midrst_async: got we=%b pend=%b g=%b expected 0 0000 00", RegWrite, pend, grant); end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (RegWrite !== 1'b0) begin fails++; $display("FAIL midrst_stale%0d: got we=%b d=%h expected 0", i, RegWrite, WriteD); end
        end
    endtask

`ifdef REGARB_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        fwd_addr = 2'd0;
        req1_valid = 1'b1; req1_addr = 2'd2; req1_data = 8'h33;
        tick();
        idle_inputs();
        fwd_addr = 2'd2;
        #1;
        tests++; if (fwd_hit !== 1'b1 || fwd_data !== 8'h33) begin fails++; $display("FAIL fwd_hit: got %b %h expected 1 33", fwd_hit, fwd_data); end
        fwd_addr = 2'd1;
        #1;
        tests++; if (fwd_hit !== 1'b0 || fwd_data !== 8'h00) begin fails++; $display("FAIL fwd_miss: got %b %h expected 0 00", fwd_hit, fwd_data); end
        tick();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        idle_inputs();
`ifdef REGARB_BYPASS_EN
        fwd_addr = 2'd0;
`endif
        test_reset();
        test_single_write();
        test_dual_diff_addr();
        test_same_addr();
        test_back_to_back();
        test_reset_midstream();
`ifdef REGARB_BYPASS_EN
        test_bypass();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
